// File: rtl/memory_burst.sv
// Burst memory: request, write-data and read-data channels with byte strobes,
// address wrap/range checking and a one-cycle completion/error response.
module memory_burst #(
    parameter int unsigned MEMORY_WIDTH  = 32,
    parameter int unsigned MEMORY_DEPTH  = 16,
    parameter int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
    parameter int unsigned MAX_BURST     = 8,
    parameter int unsigned LEN_WIDTH     = $clog2(MAX_BURST),
    parameter int unsigned WRAP_EN       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      wr_rd_i,
    input  logic [ADDRESS_WIDTH-1:0]  addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    input  logic [MEMORY_WIDTH-1:0]   wdata_i,
    input  logic [MEMORY_WIDTH/8-1:0] wstrb_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [MEMORY_WIDTH-1:0]   rdata_o,
    output logic                      rlast_o,
    output logic                      done_o,
    output logic                      err_o
);
    localparam int unsigned STRB_WIDTH = MEMORY_WIDTH / 8;
    localparam int unsigned CUR_WIDTH  = ADDRESS_WIDTH + 1;
    localparam int unsigned LEN_EXT    = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_LOAD,
        S_READ,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic [CUR_WIDTH-1:0]    r_addr;
    logic [LEN_WIDTH-1:0]    r_left;
    logic                    r_err;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [MEMORY_WIDTH-1:0] r_rdata;

    logic                    w_ready;
    logic                    w_wready;
    logic                    w_done;
    logic                    w_req_hs;
    logic                    w_wr_hs;
    logic                    w_rd_hs;
    logic                    w_in_range;
    logic                    w_last;
    logic [CUR_WIDTH-1:0]    w_addr_next;
    logic [LEN_WIDTH-1:0]    w_len_clamped;
    logic [MEMORY_WIDTH-1:0] w_rd_word;

    // Handshakes, address advance and range check for the current beat.
    always_comb begin
        w_ready       = (r_state == S_IDLE) && !rst_i;
        w_wready      = (r_state == S_WRITE) && !rst_i;
        w_done        = (r_state == S_RESP);
        w_req_hs      = valid_i && w_ready;
        w_wr_hs       = wvalid_i && w_wready;
        w_rd_hs       = (r_state == S_READ) && r_rvalid && rready_i;
        w_in_range    = r_addr < CUR_WIDTH'(MEMORY_DEPTH);
        w_last        = (r_left == '0);
        w_len_clamped = len_i;
        if ({1'b0, len_i} >= LEN_EXT'(MAX_BURST)) begin
            w_len_clamped = LEN_WIDTH'(MAX_BURST - 1);
        end
        if (WRAP_EN != 0) begin
            w_addr_next = (r_addr == CUR_WIDTH'(MEMORY_DEPTH - 1)) ? '0 : r_addr + CUR_WIDTH'(1);
        end else begin
            w_addr_next = r_addr + CUR_WIDTH'(1);
        end
        w_rd_word = '0;
        if (w_in_range) begin
            w_rd_word = mem[r_addr[ADDRESS_WIDTH-1:0]];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_req_hs) w_next = wr_rd_i ? S_WRITE : S_READ_LOAD;
            S_WRITE:     if (w_wr_hs && w_last) w_next = S_RESP;
            S_READ_LOAD: w_next = S_READ;
            S_READ:      if (w_rd_hs && r_rlast) w_next = S_RESP;
            S_RESP:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst bookkeeping and the read-data register; a read handshake on a
    // non-final beat reloads in the same cycle for one beat per clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr   <= '0;
            r_left   <= '0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_req_hs) begin
                r_addr <= {1'b0, addr_i};
                r_left <= w_len_clamped;
                r_err  <= 1'b0;
            end
            if (w_wr_hs) begin
                r_addr <= w_addr_next;
                if (!w_last) r_left <= r_left - LEN_WIDTH'(1);
                if (!w_in_range) r_err <= 1'b1;
            end
            if ((r_state == S_READ_LOAD) || (w_rd_hs && !r_rlast)) begin
                r_rdata  <= w_rd_word;
                r_rvalid <= 1'b1;
                r_rlast  <= w_last;
                r_addr   <= w_addr_next;
                if (!w_last) r_left <= r_left - LEN_WIDTH'(1);
                if (!w_in_range) r_err <= 1'b1;
            end else if (w_rd_hs) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    // Strobed write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_hs && w_in_range) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (wstrb_i[k]) begin
                    mem[r_addr[ADDRESS_WIDTH-1:0]][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign ready_o  = w_ready;
    assign wready_o = w_wready;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign rlast_o  = r_rlast;
    assign done_o   = w_done;
    assign err_o    = w_done && r_err;

endmodule

// File: tb/tb_memory_burst.sv
// Scoreboard bench: one wrapping 16-word instance and one non-wrapping 12-word
// instance share stimulus; each is checked against its own array model.
`timescale 1ns/1ps
module tb_memory_burst;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          wr_rd_i;
    logic [AW-1:0] addr_i;
    logic [LW-1:0] len_i;
    logic          wvalid_i;
    logic [W-1:0]  wdata_i;
    logic [3:0]    wstrb_i;
    logic          rready_i;

    logic         ready  [2];
    logic         wready [2];
    logic         rvalid [2];
    logic         rlast  [2];
    logic         done   [2];
    logic         err    [2];
    logic [W-1:0] rdata  [2];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mdl [2][16];
    int unsigned  depth_of [2] = '{16, 12};
    bit           wrap_of  [2] = '{1'b1, 1'b0};
    logic [W:0]   exp_rd [2][$];
    bit           exp_rs [2][$];

    logic [W-1:0] bd [8];
    logic [3:0]   bs [8];

    bit       pat_mode = 1'b0;
    bit [3:0] pat      = 4'b1001;
    int       cyc      = 0;

    always #5 clk_i = ~clk_i;

    memory_burst #(.MEMORY_DEPTH(16), .WRAP_EN(1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready[0]),
        .wr_rd_i(wr_rd_i), .addr_i(addr_i), .len_i(len_i),
        .wvalid_i(wvalid_i), .wready_o(wready[0]), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rvalid_o(rvalid[0]), .rready_i(rready_i), .rdata_o(rdata[0]), .rlast_o(rlast[0]),
        .done_o(done[0]), .err_o(err[0]));

    memory_burst #(.MEMORY_DEPTH(12), .WRAP_EN(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready[1]),
        .wr_rd_i(wr_rd_i), .addr_i(addr_i), .len_i(len_i),
        .wvalid_i(wvalid_i), .wready_o(wready[1]), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rvalid_o(rvalid[1]), .rready_i(rready_i), .rdata_o(rdata[1]), .rlast_o(rlast[1]),
        .done_o(done[1]), .err_o(err[1]));

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic logic sig_of(input int which);
        case (which)
            0:       return ready[0];
            1:       return wready[0];
            default: return done[0];
        endcase
    endfunction

    // Bounded wait (at negedge) for ready/wready/done of the first instance.
    task automatic wait_sig(input int which, input string name);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!sig_of(which) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!sig_of(which)) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got 0 expected 1", name);
        end
    endtask

    // rready: random by default, fixed 1,0,0,1 pattern when pat_mode is set.
    initial begin
        rready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            rready_i = pat_mode ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: addresses, ranges and data derived from the burst rules.
    task automatic model_burst(input bit wr, input int unsigned addr, input int unsigned len);
        int unsigned a;
        bit          e;
        bit          inr;
        for (int d = 0; d < 2; d++) begin
            a = addr;
            e = 1'b0;
            for (int i = 0; i <= int'(len); i++) begin
                inr = (a < depth_of[d]);
                if (!inr) e = 1'b1;
                if (wr) begin
                    if (inr)
                        for (int k = 0; k < 4; k++)
                            if (bs[i][k]) mdl[d][a][8*k +: 8] = bd[i][8*k +: 8];
                end else begin
                    exp_rd[d].push_back({(i == int'(len)), (inr ? mdl[d][a] : {W{1'b0}})});
                end
                if (wrap_of[d]) a = (a == depth_of[d] - 1) ? 0 : a + 1;
                else a = a + 1;
            end
            exp_rs[d].push_back(e);
        end
    endtask

    task automatic burst(input bit wr, input int unsigned addr, input int unsigned len);
        model_burst(wr, addr, len);
        valid_i = 1'b1;
        wr_rd_i = wr;
        addr_i  = AW'(addr);
        len_i   = LW'(len);
        wait_sig(0, "ready");
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        addr_i  = AW'($urandom);
        len_i   = LW'($urandom);
        if (wr) begin
            for (int i = 0; i <= int'(len); i++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk_i);
                    #1;
                end
                wvalid_i = 1'b1;
                wdata_i  = bd[i];
                wstrb_i  = bs[i];
                wait_sig(1, "wready");
                @(posedge clk_i);
                #1;
                wvalid_i = 1'b0;
            end
        end
        wait_sig(2, "done");
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every presented read beat must match the queue head; pops on handshake.
    always @(negedge clk_i) begin : monitor
        logic [W:0] e;
        if (!rst_i) begin
            for (int d = 0; d < 2; d++) begin
                if (rvalid[d]) begin
                    if (exp_rd[d].size() == 0) begin
                        chk($sformatf("rd_unexpected%0d", d), W'(rvalid[d]), '0);
                    end else begin
                        e = exp_rd[d][0];
                        chk($sformatf("rdata%0d", d), rdata[d], e[W-1:0]);
                        chk($sformatf("rlast%0d", d), W'(rlast[d]), W'(e[W]));
                        if (rready_i) void'(exp_rd[d].pop_front());
                    end
                end
                if (done[d]) begin
                    if (exp_rs[d].size() == 0) begin
                        chk($sformatf("done_unexpected%0d", d), W'(done[d]), '0);
                    end else begin
                        chk($sformatf("err%0d", d), W'(err[d]), W'(exp_rs[d].pop_front()));
                    end
                end else if (err[d]) begin
                    chk($sformatf("err_without_done%0d", d), W'(err[d]), '0);
                end
            end
        end
    end

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        wr_rd_i  = 1'b0;
        addr_i   = '0;
        len_i    = '0;
        wvalid_i = 1'b0;
        wdata_i  = '0;
        wstrb_i  = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d),  W'(ready[d]),  '0);
            chk($sformatf("rst_wready%0d", d), W'(wready[d]), '0);
            chk($sformatf("rst_rvalid%0d", d), W'(rvalid[d]), '0);
            chk($sformatf("rst_rlast%0d", d),  W'(rlast[d]),  '0);
            chk($sformatf("rst_done%0d", d),   W'(done[d]),   '0);
            chk($sformatf("rst_err%0d", d),    W'(err[d]),    '0);
            chk($sformatf("rst_rdata%0d", d),  rdata[d],      '0);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) chk($sformatf("ready_after_rst%0d", d), W'(ready[d]), W'(1));
        @(posedge clk_i);
        #1;

        // Fill every location so the model is fully known.
        for (int i = 0; i < 8; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
        burst(1'b1, 0, 7);
        for (int i = 0; i < 8; i++) bd[i] = $urandom;
        burst(1'b1, 8, 7);

        // Basic 4-beat write then read.
        bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33; bd[3] = 32'h44;
        for (int i = 0; i < 4; i++) bs[i] = 4'hF;
        burst(1'b1, 0, 3);
        burst(1'b0, 0, 3);

        // Byte-strobe merge into a preloaded word.
        bd[0] = 32'hAABBCCDD; bs[0] = 4'hF;
        burst(1'b1, 5, 0);
        bd[0] = 32'h11223344; bs[0] = 4'b0101;
        burst(1'b1, 5, 0);
        burst(1'b0, 5, 0);
        chk("backdoor_mem5_a", dut_a.mem[5], 32'hAA22CC44);
        chk("backdoor_mem5_b", dut_b.mem[5], 32'hAA22CC44);

        // Wrap vs range error at the top of memory.
        for (int i = 0; i < 4; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
        burst(1'b1, 14, 3);
        burst(1'b0, 14, 3);
        burst(1'b0, 10, 3);

        // Read with rready 1,0,0,1 backpressure.
        pat_mode = 1'b1;
        burst(1'b0, 2, 4);
        pat_mode = 1'b0;

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin bd[i] = $urandom; bs[i] = 4'($urandom); end
            burst(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 7));
        end

        // Reset on the second beat of a 4-beat write.
        valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = AW'(8); len_i = LW'(3);
        wait_sig(0, "ready");
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        bd[0] = $urandom; bs[0] = 4'hF;
        for (int d = 0; d < 2; d++) mdl[d][8] = bd[0];
        wvalid_i = 1'b1; wdata_i = bd[0]; wstrb_i = 4'hF;
        wait_sig(1, "wready");
        @(posedge clk_i);
        #1;
        wdata_i = $urandom; wstrb_i = 4'h0; rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        wdata_i = $urandom; wstrb_i = 4'hF;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; wvalid_i = 1'b0;
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready_after_abort%0d", d), W'(ready[d]), W'(1));
            chk($sformatf("done_after_abort%0d", d),  W'(done[d]),  '0);
        end
        @(posedge clk_i);
        #1;
        burst(1'b0, 8, 3);

        repeat (4) @(posedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd_queue_empty%0d", d), W'(exp_rd[d].size()), '0);
            chk($sformatf("rs_queue_empty%0d", d), W'(exp_rs[d].size()), '0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
